// File: rtl/uart_tx_ctrl_if.sv
// Purpose: bundles the request side and TX-mux drive side of the UART frame sequencer.
// Latency: none (wires only).
// Backpressure: requester drives data_valid and watches ready; no queueing behind it.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    // Request side
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;

    // TX output mux drive and status
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  parity_bit;
    logic                  busy;
    logic                  ready;

    // Requester / bench side
    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        input  mux_sel,
        input  ser_data,
        input  parity_bit,
        input  busy,
        input  ready
    );

    // Frame sequencer side
    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        output mux_sel,
        output ser_data,
        output parity_bit,
        output busy,
        output ready
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Purpose: UART frame sequencer: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Latency: request accepted at edge N shows START in cycle N+1; frame is 2+DATA_WIDTH+par_en cycles.
// Backpressure: ready only in IDLE/STOP; data_valid while not ready is ignored, requester must hold.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  tx
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q,   state_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  parity_q,  parity_d;
    logic [1:0]            mux_sel_q, mux_sel_d;
    logic                  busy_q,    busy_d;
    logic                  ready_q,   ready_d;
    logic                  accept;

    // ready_q is registered from the state, so it equals "state is IDLE or STOP" in this cycle.
    assign accept = ready_q & tx.data_valid;

    // Next-state, datapath and registered-output decode for the frame walk.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        parity_d  = parity_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_START: begin
                state_d = S_DATA;
                cnt_d   = '0;
            end
            S_DATA: begin
                shift_d = shift_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    // Hold the counter on the last bit so it never wraps inside a frame.
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Acceptance is only possible from IDLE or STOP; from STOP it chains frames with no gap.
        if (accept) begin
            state_d   = S_START;
            shift_d   = tx.p_data;
            par_en_d  = tx.par_en;
            par_typ_d = tx.par_typ;
            parity_d  = (^tx.p_data) ^ tx.par_typ;
        end

        unique case (state_d)
            S_START:  mux_sel_d = SEL_START;
            S_DATA:   mux_sel_d = SEL_DATA;
            S_PARITY: mux_sel_d = SEL_PARITY;
            default:  mux_sel_d = SEL_STOP;
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE) || (state_d == S_STOP);
    end

    // State, datapath and Moore outputs; reset wins over any same-edge request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            parity_q  <= 1'b0;
            mux_sel_q <= SEL_STOP;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            parity_q  <= parity_d;
            mux_sel_q <= mux_sel_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign tx.mux_sel    = mux_sel_q;
    assign tx.ser_data   = shift_q[0];
    assign tx.parity_bit = parity_q;
    assign tx.busy       = busy_q;
    assign tx.ready      = ready_q;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame sequencer for the UART transmitter. It accepts a parallel word with a valid strobe and latches the word together with the parity configuration. It then walks the frame start → data (LSB first) → optional parity → stop, one bit per CLK. It drives the 2-bit select, serial data bit and parity bit of the TX output mux; the mux forms the line value from those three signals.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per frame payload; legal range 2..16.

Ports:
- CLK  in  1  bit clock; one transmitted bit per rising edge.
- RST  in  1  synchronous, active-high reset, sampled on rising CLK.
- p_data  in  DATA_WIDTH  parallel word to transmit.
- data_valid  in  1  request strobe; p_data, par_en and par_typ are sampled with it.
- par_en  in  1  1 = insert parity bit after data.
- par_typ  in  1  0 = even parity, 1 = odd parity.
- mux_sel  out  2  mux select: 00 start, 01 data, 10 parity, 11 stop/idle.
- ser_data  out  1  current data bit for the mux data input.
- parity_bit  out  1  parity of the latched word for the mux parity input.
- busy  out  1  high while a frame is in progress (any state except IDLE).
- ready  out  1  high when data_valid will be accepted (IDLE or STOP).

## Operation
- States: IDLE, START, DATA, PARITY, STOP. All outputs are Moore outputs, decoded from state and registered data.
- mux_sel per state:
  - IDLE: 11.
  - START: 00.
  - DATA: 01.
  - PARITY: 10.
  - STOP: 11.
- Acceptance: on a rising edge with ready=1 and data_valid=1, the block latches:
  - p_data into a DATA_WIDTH shift register;
  - par_en and par_typ into configuration registers;
  - parity_bit = (^p_data) ^ par_typ.
  - Next state is START.
- IDLE: stays in IDLE unless data is accepted.
- START: 1 cycle, then DATA. The bit counter clears to 0.
- DATA:
  - ser_data = shift-register bit 0.
  - Each cycle the register shifts right (shift in 0) and the counter increments.
  - After DATA_WIDTH cycles (counter = DATA_WIDTH-1 at the edge), next state is PARITY if latched par_en=1, else STOP.
- PARITY: 1 cycle, then STOP.
- STOP: 1 cycle. Next state is START if data is accepted on that edge (back-to-back, no idle gap), else IDLE.
- data_valid is ignored when ready=0. No error or queueing; the requester must hold or retry.
- Inputs p_data, par_en and par_typ may change freely after acceptance; the frame uses the latched values only.
- Bit counter width: $clog2(DATA_WIDTH); it never wraps within a frame.

## Timing
- Reset values (after an edge with RST=1):
  - state IDLE;
  - mux_sel 11; ser_data 0; parity_bit 0;
  - busy 0; ready 1;
  - shift register 0; bit counter 0; configuration registers 0.
- RST has priority over data_valid on the same edge; that request is dropped.
- Reset mid-frame aborts the frame. The next cycle shows mux_sel=11, busy=0, and no remaining bits are emitted.
- Latency: data_valid accepted at edge N → mux_sel=00 during cycle N+1.
  - Data bit i is presented during cycle N+2+i.
  - Parity (if enabled) during N+2+DATA_WIDTH.
  - Stop during N+2+DATA_WIDTH+par_en.
- Frame length: 2+DATA_WIDTH+par_en cycles, i.e. 10 or 11 at the default. Back-to-back frames repeat with exactly this period.
- ser_data is only meaningful while mux_sel=01. parity_bit holds from START through STOP and changes only on acceptance.
- busy rises in the cycle after acceptance from IDLE and falls the cycle after STOP when no new request is accepted.

## Test plan
- Reset then idle: hold RST=1 for 2 cycles, release, data_valid=0 for 20 cycles → mux_sel=11, busy=0, ready=1 throughout.
- Even parity frame: p_data=0xA5, par_en=1, par_typ=0, one-cycle data_valid → per cycle:
  - mux_sel 00, then 01×8 with ser_data 1,0,1,0,0,1,0,1, then 10 with parity_bit=0, then 11;
  - busy high for 11 cycles, then IDLE.
- Odd parity and parity off:
  - 0x01 with par_typ=1 → parity_bit=0;
  - 0x01 with par_en=0 → frame of 10 cycles with no 10 select;
  - 0x01 with par_en=1, par_typ=0 → parity_bit=1.
- Back-to-back: hold data_valid=1, sending 0x3C then 0xFF (par_en=0) → second START immediately follows the first STOP; period exactly 10 cycles; no 11 gap beyond the single stop bit.
- Busy rejection: assert data_valid with 0x55 during DATA of a frame carrying 0xA5 → ignored; the current frame bits are unchanged and no second frame starts.
- Mid-frame reset: RST=1 for one cycle on the 3rd data bit of a 0xF0 frame → next cycle mux_sel=11, busy=0; a subsequent request 0x0F transmits correctly from START.
